// File: rtl/axil_ram_fill_ctrl.sv
// rtl/axil_ram_fill_ctrl.sv - AXI-Lite master that fills a word range with a constant or incrementing pattern
module axil_ram_fill_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] cfg_fill,
    input  logic                  cfg_incr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_done,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  words_q;
    logic                  incr_q;
    logic                  err_q;
    logic                  aborted_q;
    logic                  abort_pend;
    logic                  awvalid_q, wvalid_q;
    logic                  awvalid_next, wvalid_next;
    logic                  accept, b_hs, last_word, abort_now, finish_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        b_hs         = 1'b0;
        finish_run   = 1'b0;
        awvalid_next = awvalid_q;
        wvalid_next  = wvalid_q;
        abort_now    = abort_pend | abort;
        last_word    = (words_q + LEN_WIDTH'(1)) == len_q;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (cfg_len == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next   = ISSUE;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // A channel whose valid is already low has completed its handshake.
                awvalid_next = awvalid_q & ~m_axil_awready;
                wvalid_next  = wvalid_q & ~m_axil_wready;
                if (!awvalid_next && !wvalid_next) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (m_axil_bvalid) begin
                    b_hs = 1'b1;
                    if (last_word || abort_now) begin
                        finish_run = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next   = ISSUE;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            data_q     <= '0;
            len_q      <= '0;
            words_q    <= '0;
            incr_q     <= 1'b0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            abort_pend <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
        end else begin
            awvalid_q <= awvalid_next;
            wvalid_q  <= wvalid_next;
            if (accept) begin
                addr_q     <= cfg_base;
                data_q     <= cfg_fill;
                len_q      <= cfg_len;
                incr_q     <= cfg_incr;
                words_q    <= '0;
                err_q      <= 1'b0;
                aborted_q  <= 1'b0;
                abort_pend <= 1'b0;
            end else begin
                if ((state == ISSUE || state == RESP) && abort) begin
                    abort_pend <= 1'b1;
                end
                if (b_hs) begin
                    words_q <= words_q + LEN_WIDTH'(1);
                    if (m_axil_bresp != 2'b00) begin
                        err_q <= 1'b1;
                    end
                    if (finish_run) begin
                        aborted_q <= abort_now;
                    end else begin
                        addr_q <= addr_q + ADDR_WIDTH'(STRB_WIDTH);
                        if (incr_q) begin
                            data_q <= data_q + DATA_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign err            = err_q;
    assign aborted        = aborted_q;
    assign words_done     = words_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = data_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = (state == RESP);

endmodule

// File: tb/tb_axil_ram_fill_ctrl.sv
// tb/tb_axil_ram_fill_ctrl.sv - directed bench for axil_ram_fill_ctrl with a behavioural AXI-Lite slave
module tb_axil_ram_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  cfg_base;
    logic [8:0]  cfg_len;
    logic [15:0] cfg_fill;
    logic        cfg_incr;
    logic        abort;
    logic        busy, done, err, aborted;
    logic [8:0]  words_done;
    logic [8:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave model state and observation log
    logic [8:0]  aw_q[$];
    logic [15:0] w_q[$];
    int aw_stall = 0, err_word = -1, b_cnt = 0, last_b_cyc = -1, first_aw_cyc = -1;
    int split_cnt = 0, aw_starts = 0, viol = 0, strb_bad = 0, done_cnt = 0;
    logic aw_seen, w_seen, b_pend, p_aw_wait, p_w_wait, aw_prev;
    logic [8:0]  p_addr;
    logic [15:0] p_data;
    int start_cyc, done_cyc;
    logic busy_at_start;

    axil_ram_fill_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .cfg_fill(cfg_fill), .cfg_incr(cfg_incr), .abort(abort), .busy(busy), .done(done),
        .err(err), .aborted(aborted), .words_done(words_done),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave decides its inputs on the falling edge and predicts handshakes at the next rising edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_seen = 1'b0; w_seen = 1'b0; b_pend = 1'b0;
            p_aw_wait = 1'b0; p_w_wait = 1'b0; aw_prev = 1'b0;
        end else begin
            if (p_aw_wait && (!awvalid || awaddr !== p_addr)) viol++;
            if (p_w_wait && (!wvalid || wdata !== p_data)) viol++;
            if (b_pend) begin bvalid = 1'b0; b_pend = 1'b0; end
            if (aw_seen && w_seen && !bvalid) begin
                bvalid = 1'b1;
                bresp = (b_cnt == err_word) ? 2'b10 : 2'b00;
                aw_seen = 1'b0; w_seen = 1'b0;
            end
            if (awvalid && !wvalid) split_cnt++;
            if (awvalid && !aw_prev) aw_starts++;
            aw_prev = awvalid;
            if (awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
            if (done) done_cnt++;
            if (awprot !== 3'b000) viol++;
            awready = 1'b1;
            if (awvalid && aw_stall > 0) begin awready = 1'b0; aw_stall--; end
            wready = 1'b1;
            p_aw_wait = awvalid && !awready; p_addr = awaddr;
            p_w_wait  = wvalid && !wready;   p_data = wdata;
            if (awvalid && awready) begin aw_q.push_back(awaddr); aw_seen = 1'b1; end
            if (wvalid && wready) begin
                w_q.push_back(wdata);
                if (wstrb !== 2'b11) strb_bad++;
                w_seen = 1'b1;
            end
            if (bvalid && bready) begin b_pend = 1'b1; b_cnt++; last_b_cyc = cyc + 1; end
        end
    end

    task automatic run(input logic [8:0] b, input logic [8:0] l, input logic [15:0] f, input logic inc);
        aw_q.delete(); w_q.delete();
        b_cnt = 0; last_b_cyc = -1; first_aw_cyc = -1; split_cnt = 0; aw_starts = 0; done_cnt = 0;
        @(negedge clk);
        cfg_base = b; cfg_len = l; cfg_fill = f; cfg_incr = inc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        busy_at_start = busy;
        done_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin done_cyc = cyc; break; end
            @(posedge clk); #1;
        end
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout: done never seen within 300 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, err, aborted, words_done, awvalid, wvalid, bready, awaddr, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b ab=%b wd=%h awv=%b wv=%b br=%b aw=%h wd=%h required all 0",
                     busy, done, err, aborted, words_done, awvalid, wvalid, bready, awaddr, wdata);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_const_fill();
        logic [8:0] ea[4] = '{9'h010, 9'h012, 9'h014, 9'h016};
        run(9'h010, 9'd4, 16'hA5A5, 1'b0);
        checks++;
        if (aw_q.size() != 4 || w_q.size() != 4) begin
            errors++; $display("FAIL const_count: got aw=%0d w=%0d required 4/4", aw_q.size(), w_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aw_q[i] !== ea[i] || w_q[i] !== 16'hA5A5) begin
                errors++; $display("FAIL const_word%0d: got %h/%h required %h/a5a5", i, aw_q[i], w_q[i], ea[i]);
            end
        end
        checks++;
        if (err !== 1'b0 || words_done !== 9'd4 || aborted !== 1'b0) begin
            errors++; $display("FAIL const_status: got err=%b wd=%0d ab=%b required 0/4/0", err, words_done, aborted);
        end
        checks++;
        if (done_cyc != last_b_cyc || done_cnt != 1) begin
            errors++; $display("FAIL const_done_timing: got done@%0d x%0d required @%0d x1", done_cyc, done_cnt, last_b_cyc);
        end
        checks++;
        if (first_aw_cyc != start_cyc || done_cyc - start_cyc != 8) begin
            errors++; $display("FAIL const_latency: got first_aw=%0d span=%0d required %0d/8",
                               first_aw_cyc, done_cyc - start_cyc, start_cyc);
        end
        checks++;
        if (strb_bad != 0) begin
            errors++; $display("FAIL const_wstrb: got %0d bad strobes required 0", strb_bad);
        end
    endtask

    task automatic test_wrap_incr();
        logic [8:0]  ea[3] = '{9'h1FE, 9'h000, 9'h002};
        logic [15:0] ed[3] = '{16'hFFFF, 16'h0000, 16'h0001};
        run(9'h1FE, 9'd3, 16'hFFFF, 1'b1);
        checks++;
        if (aw_q.size() != 3 || w_q.size() != 3) begin
            errors++; $display("FAIL wrap_count: got aw=%0d w=%0d required 3/3", aw_q.size(), w_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_q[i] !== ea[i] || w_q[i] !== ed[i]) begin
                errors++; $display("FAIL wrap_word%0d: got %h/%h required %h/%h", i, aw_q[i], w_q[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (err !== 1'b0 || words_done !== 9'd3) begin
            errors++; $display("FAIL wrap_status: got err=%b wd=%0d required 0/3", err, words_done);
        end
    endtask

    task automatic test_zero_len();
        run(9'h040, 9'd0, 16'h1111, 1'b0);
        checks++;
        if (aw_starts != 0 || aw_q.size() != 0 || w_q.size() != 0) begin
            errors++; $display("FAIL zero_len_writes: got awstarts=%0d aw=%0d w=%0d required 0", aw_starts, aw_q.size(), w_q.size());
        end
        checks++;
        if (busy_at_start !== 1'b1 || done_cyc != start_cyc || busy !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_len_timing: got busy0=%b done@%0d busy1=%b n=%0d required 1 @%0d 0 1",
                               busy_at_start, done_cyc, busy, done_cnt, start_cyc);
        end
        checks++;
        if (words_done !== 9'd0 || err !== 1'b0) begin
            errors++; $display("FAIL zero_len_status: got wd=%0d err=%b required 0/0", words_done, err);
        end
    endtask

    task automatic test_stall_err();
        logic [8:0]  ea[4] = '{9'h020, 9'h022, 9'h024, 9'h026};
        logic [15:0] ed[4] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        aw_stall = 3; err_word = 1;
        run(9'h020, 9'd4, 16'h0100, 1'b1);
        err_word = -1;
        checks++;
        if (split_cnt != 3 || viol != 0) begin
            errors++; $display("FAIL stall_split: got split=%0d viol=%0d required 3/0", split_cnt, viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (aw_q[i] !== ea[i] || w_q[i] !== ed[i]) begin
                errors++; $display("FAIL stall_word%0d: got %h/%h required %h/%h", i, aw_q[i], w_q[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (err !== 1'b1 || words_done !== 9'd4 || aw_q.size() != 4) begin
            errors++; $display("FAIL stall_err: got err=%b wd=%0d n=%0d required 1/4/4", err, words_done, aw_q.size());
        end
    endtask

    task automatic test_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b aborted=%b required 0/0", busy, aborted);
        end
        fork
            run(9'h080, 9'd8, 16'h00AA, 1'b1);
            begin
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk); #1;
                    if (awvalid && b_cnt == 1) break;
                end
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end
        join
        checks++;
        if (aborted !== 1'b1 || words_done !== 9'd2) begin
            errors++; $display("FAIL abort_status: got aborted=%b wd=%0d required 1/2", aborted, words_done);
        end
        checks++;
        if (aw_starts != 2 || aw_q.size() != 2 || w_q.size() != 2) begin
            errors++; $display("FAIL abort_writes: got starts=%0d aw=%0d w=%0d required 2", aw_starts, aw_q.size(), w_q.size());
        end
        checks++;
        if (aw_q[1] !== 9'h082 || w_q[1] !== 16'h00AB) begin
            errors++; $display("FAIL abort_word1: got %h/%h required 082/00ab", aw_q[1], w_q[1]);
        end
        run(9'h0C0, 9'd2, 16'h0001, 1'b0);
        checks++;
        if (aborted !== 1'b0 || words_done !== 9'd2) begin
            errors++; $display("FAIL abort_cleared: got aborted=%b wd=%0d required 0/2", aborted, words_done);
        end
    endtask

    task automatic test_reset_mid_run();
        aw_q.delete(); w_q.delete(); b_cnt = 0;
        @(negedge clk);
        cfg_base = 9'h040; cfg_len = 9'd4; cfg_fill = 16'h5555; cfg_incr = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bready && words_done == 9'd1) break;
            @(posedge clk); #1;
        end
        checks++;
        if (bready !== 1'b1 || awaddr !== 9'h042) begin
            errors++; $display("FAIL rst_mid_setup: got bready=%b awaddr=%h required 1/042", bready, awaddr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, aborted, words_done, awvalid, wvalid, bready, awaddr, wdata} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got busy=%b wd=%h br=%b aw=%h wdat=%h required all 0",
                               busy, words_done, bready, awaddr, wdata);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run(9'h100, 9'd1, 16'h1234, 1'b0);
        checks++;
        if (err !== 1'b0 || words_done !== 9'd1 || aw_q.size() != 1 || aw_q[0] !== 9'h100 || w_q[0] !== 16'h1234) begin
            errors++; $display("FAIL rst_mid_rerun: got err=%b wd=%0d n=%0d aw=%h wd=%h required 0/1/1/100/1234",
                               err, words_done, aw_q.size(), aw_q[0], w_q[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_base = '0; cfg_len = '0; cfg_fill = '0; cfg_incr = 1'b0;
        test_reset();
        test_const_fill();
        test_wrap_incr();
        test_zero_len();
        test_stall_err();
        test_abort();
        test_reset_mid_run();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL protocol_hold: got %0d violations required 0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
